// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared Ascon-128 types, constants and padding helpers
package ascon_pkg;

    localparam int RATE_BYTES = 8;
    localparam int PB_ROUNDS  = 6;

    typedef logic [0:4][63:0] state_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_AD,
        PERM,
        PAD,
        FINAL
    } fsm_e;

    localparam logic [7:0] RC [0:11] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    localparam logic [63:0] IV        = 64'h8040_0c06_0000_0000;
    localparam logic [63:0] PAD_BLOCK = 64'h8000_0000_0000_0000;
    localparam logic [63:0] DSEP      = 64'h0000_0000_0000_0001;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        logic [127:0] t;
        t = {x, x} >> n;
        return t[63:0];
    endfunction

    // Byte counts of 0 or above 8 on a final block behave as a full block.
    function automatic logic [3:0] eff_bytes(input logic [3:0] nbytes, input logic last);
        return (last && nbytes != 4'd0 && nbytes < 4'd8) ? nbytes : 4'd8;
    endfunction

    function automatic logic [63:0] pad_block(input logic [63:0] data,
                                              input logic [3:0]  nbytes,
                                              input logic        last);
        logic [3:0]  n;
        logic [63:0] blk;
        n   = eff_bytes(nbytes, last);
        blk = '0;
        for (int i = 0; i < RATE_BYTES; i++) begin
            if (4'(i) < n) begin
                blk[63-8*i -: 8] = data[63-8*i -: 8];
            end else if (4'(i) == n) begin
                blk[63-8*i -: 8] = 8'h80;
            end
        end
        return blk;
    endfunction

    // A full final block carries no padding and needs an extra padding block.
    function automatic logic needs_pad(input logic [3:0] nbytes, input logic last);
        return last && (eff_bytes(nbytes, last) == 4'd8);
    endfunction

endpackage

// File: rtl/ascon_ad_absorb_if.sv
// rtl/ascon_ad_absorb_if.sv - associated-data block stream with valid/ready handshake
interface ascon_ad_absorb_if;
    logic        ad_valid;
    logic [63:0] ad_data;
    logic [3:0]  ad_bytes;
    logic        ad_last;
    logic        ad_ready;

    modport master (output ad_valid, ad_data, ad_bytes, ad_last, input ad_ready);
    modport slave  (input ad_valid, ad_data, ad_bytes, ad_last, output ad_ready);
endinterface

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round (constant, s-box, linear layer)
module ascon_round
    import ascon_pkg::*;
(
    input  state_t     state_i,
    input  logic [7:0] rc_i,
    output state_t     state_o
);

    // S-box as a lookup table; bit 4 of the index/result is word 0.
    localparam logic [4:0] SBOX [0:31] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    state_t     x;
    state_t     s;
    logic [4:0] col;
    logic [4:0] sub;

    always_comb begin
        x    = state_i;
        x[2] = state_i[2] ^ {56'h0, rc_i};
        s    = '0;
        col  = '0;
        sub  = '0;
        for (int i = 0; i < 64; i++) begin
            col     = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
            sub     = SBOX[col];
            s[0][i] = sub[4];
            s[1][i] = sub[3];
            s[2][i] = sub[2];
            s[3][i] = sub[1];
            s[4][i] = sub[0];
        end
    end

    assign state_o[0] = s[0] ^ rotr(s[0], 19) ^ rotr(s[0], 28);
    assign state_o[1] = s[1] ^ rotr(s[1], 61) ^ rotr(s[1], 39);
    assign state_o[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
    assign state_o[3] = s[3] ^ rotr(s[3], 10) ^ rotr(s[3], 17);
    assign state_o[4] = s[4] ^ rotr(s[4], 7)  ^ rotr(s[4], 41);

endmodule

// File: rtl/ascon_ad_absorb.sv
// rtl/ascon_ad_absorb.sv - Ascon-128 associated-data absorption with p^6 per block
module ascon_ad_absorb
    import ascon_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                no_ad_i,
    input  state_t              state_in_i,
    ascon_ad_absorb_if.slave    ad,
    output state_t              state_out_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [2:0] LAST_CNT = 3'(PB_ROUNDS - 1);
    localparam logic [3:0] RC_BASE  = 4'(12 - PB_ROUNDS);

    fsm_e       fsm_q, fsm_d;
    state_t     state_q, state_d, round_out;
    logic [2:0] cnt_q, cnt_d;
    logic       pad_q, pad_d;
    logic       last_q, last_d;
    logic       done_q, done_d;
    logic [7:0] rc;

    assign rc = RC[RC_BASE + {1'b0, cnt_q}];

    ascon_round u_round (
        .state_i (state_q),
        .rc_i    (rc),
        .state_o (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= '0;
            pad_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pad_q   <= pad_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        pad_d   = pad_q;
        last_d  = last_q;
        done_d  = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    state_d = state_in_i;
                    pad_d   = 1'b0;
                    last_d  = 1'b0;
                    fsm_d   = no_ad_i ? FINAL : WAIT_AD;
                end
            end
            WAIT_AD: begin
                if (ad.ad_valid) begin
                    state_d[0] = state_q[0] ^ pad_block(ad.ad_data, ad.ad_bytes, ad.ad_last);
                    pad_d      = needs_pad(ad.ad_bytes, ad.ad_last);
                    last_d     = ad.ad_last;
                    cnt_d      = '0;
                    fsm_d      = PERM;
                end
            end
            PERM: begin
                state_d = round_out;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (!last_q)    fsm_d = WAIT_AD;
                    else if (pad_q) fsm_d = PAD;
                    else            fsm_d = FINAL;
                end
            end
            PAD: begin
                state_d[0] = state_q[0] ^ PAD_BLOCK;
                pad_d      = 1'b0;
                cnt_d      = '0;
                fsm_d      = PERM;
            end
            FINAL: begin
                state_d[4] = state_q[4] ^ DSEP;
                done_d     = 1'b1;
                fsm_d      = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign ad.ad_ready   = (fsm_q == WAIT_AD);
    assign busy_o        = (fsm_q != IDLE);
    assign done_o        = done_q;
    assign state_out_o   = state_q;

endmodule
